mc_latency_ctrl: RTL and testbench

MC_LATENCY_CTRL -- requirements
Module: mc_latency_ctrl

---
 rtl/mc_pkg.sv | 42 ++++
 rtl/mc_slot_shift.sv | 77 +++++++
 rtl/mc_latency_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mc_latency_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared definitions for the multi-cycle latency controller:
//               default parameter values, blocking-mode FSM state encoding,
//               FPU operation latencies and the latency clamp helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // Default configuration of the controller
    localparam int DEFAULT_MAX_LAT = 8;
    localparam int DEFAULT_TAG_W   = 5;

    // Latencies of the FPU operations this controller typically sequences
    localparam logic [3:0] FADD_LAT = 4'd7;
    localparam logic [3:0] FMUL_LAT = 4'd5;
    localparam logic [3:0] FDIV_LAT = 4'd6;

    // Blocking-mode state machine
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } blk_state_t;

    // Effective latency: 0 behaves as 1, anything above max_lat saturates.
    function automatic logic [3:0] clamp_lat(input logic [3:0] lat,
                                             input int         max_lat);
        logic [3:0] w_lat;
        if (lat == 4'd0) begin
            w_lat = 4'd1;
        end else if (int'(lat) > max_lat) begin
            w_lat = 4'(max_lat);
        end else begin
            w_lat = lat;
        end
        return w_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_slot_shift.sv
`default_nettype none
// ============================================================================
// Module      : mc_slot_shift
// Description : Completion-slot shift vector for pipelined mode. Slot i holds
//               the op that completes i edges after the coming edge; slot 0
//               therefore completes on the coming edge. Every shift moves all
//               slots one position towards slot 0. A load writes an entry at
//               load_idx in post-shift coordinates.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               clear             - discard every entry (flush)
//               shift             - advance all slots by one position
//               load, load_idx    - write a new entry at load_idx
//               load_tag          - tag stored with the new entry
//               slot0_valid/_tag  - entry completing on the coming edge
//               occ               - per-slot valid (occupancy) vector
// Revision    : 1.0 - initial release
// ============================================================================
module mc_slot_shift #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 5,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [TAG_W-1:0] load_tag,
    output logic             slot0_valid,
    output logic [TAG_W-1:0] slot0_tag,
    output logic [DEPTH-1:0] occ
);

    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag   [DEPTH];
    logic [DEPTH-1:0] w_nxt_v;
    logic [TAG_W-1:0] w_nxt_t [DEPTH];

    // Next-state per slot: shifted neighbour (or hold), overridden by a load.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             w_sv;
        logic [TAG_W-1:0] w_st;
        logic             w_hit;

        if (i == DEPTH - 1) begin : g_top
            // Nothing shifts into the farthest slot.
            assign w_sv = shift ? 1'b0 : r_valid[i];
            assign w_st = shift ? '0   : r_tag[i];
        end else begin : g_mid
            assign w_sv = shift ? r_valid[i+1] : r_valid[i];
            assign w_st = shift ? r_tag[i+1]   : r_tag[i];
        end

        assign w_hit      = load && (load_idx == IDX_W'(i));
        assign w_nxt_v[i] = w_hit | w_sv;
        assign w_nxt_t[i] = w_hit ? load_tag : w_st;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_valid <= w_nxt_v;
            r_tag   <= w_nxt_t;
        end
    end

    assign slot0_valid = r_valid[0];
    assign slot0_tag   = r_tag[0];
    assign occ         = r_valid;

endmodule
`default_nettype wire

// File: rtl/mc_latency_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_latency_ctrl
// Description : Sequencer for variable-latency multi-cycle operations. Each
//               accepted op returns its tag on a one-cycle done pulse exactly
//               L edges after acceptance (L = issue_lat clamped to
//               1..MAX_LAT). PIPELINED=0 keeps a single op in flight with a
//               down-counter FSM; PIPELINED=1 accepts one op per cycle and
//               refuses any op whose completion cycle is already taken.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               issue_valid/lat/tag   - op request, its latency and tag
//               flush                 - discard every in-flight op
//               issue_ready           - request is accepted this cycle
//               stall                 - issue_valid & ~issue_ready
//               done_valid/done_tag   - registered completion pulse and tag
//               busy                  - any op in flight
//               inflight              - number of ops in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mc_latency_ctrl
    import mc_pkg::*;
#(
    parameter int MAX_LAT   = DEFAULT_MAX_LAT,
    parameter int TAG_W     = DEFAULT_TAG_W,
    parameter int PIPELINED = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [3:0]                   issue_lat,
    input  logic [TAG_W-1:0]             issue_tag,
    input  logic                         flush,
    output logic                         issue_ready,
    output logic                         stall,
    output logic                         done_valid,
    output logic [TAG_W-1:0]             done_tag,
    output logic                         busy,
    output logic [$clog2(MAX_LAT+1)-1:0] inflight
);

    localparam int INF_W = $clog2(MAX_LAT + 1);

    logic [3:0]       w_eff_lat;
    logic             w_ready;
    logic             w_done_valid;
    logic [TAG_W-1:0] w_done_tag;
    logic [INF_W-1:0] w_inflight;

    assign w_eff_lat = clamp_lat(issue_lat, MAX_LAT);

    if (PIPELINED == 0) begin : g_blocking
        // --------------------------------------------------------------------
        // One op in flight. r_cnt holds the edges still to wait before the
        // done edge; the done edge is the one seen with r_cnt == 0.
        // --------------------------------------------------------------------
        blk_state_t       r_state;
        logic [3:0]       r_cnt;
        logic [TAG_W-1:0] r_tag;
        logic             r_done_valid;
        logic [TAG_W-1:0] r_done_tag;
        logic             w_last;
        logic             w_accept;

        // The op in flight completes on the coming edge.
        assign w_last   = (r_state == COUNT) && (r_cnt == 4'd0);
        // Ready when empty or when the slot frees on this very edge.
        assign w_ready  = (r_state == IDLE) || w_last;
        assign w_accept = issue_valid && w_ready && !flush;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_state      <= IDLE;
                r_cnt        <= 4'd0;
                r_tag        <= '0;
                r_done_valid <= 1'b0;
                r_done_tag   <= '0;
            end else begin
                r_done_valid <= 1'b0;
                r_done_tag   <= '0;
                if (w_last) begin
                    r_done_valid <= 1'b1;
                    r_done_tag   <= r_tag;
                    r_state      <= IDLE;
                end else if (r_state == COUNT) begin
                    r_cnt <= r_cnt - 4'd1;
                end
                // A same-edge accept reloads the counter (back-to-back issue).
                if (w_accept) begin
                    r_state <= COUNT;
                    r_cnt   <= w_eff_lat - 4'd1;
                    r_tag   <= issue_tag;
                end
            end
        end

        assign w_done_valid = r_done_valid;
        assign w_done_tag   = r_done_tag;
        assign w_inflight   = INF_W'(r_state == COUNT);

    end else begin : g_pipelined
        // --------------------------------------------------------------------
        // One issue per cycle. The completion schedule lives in the slot
        // shift vector; an op is refused when its completion cycle is taken.
        // --------------------------------------------------------------------
        localparam int IDX_W = $clog2(MAX_LAT);

        logic [MAX_LAT-1:0] w_occ;
        logic [15:0]        w_occ_ext;
        logic               w_slot0_valid;
        logic [TAG_W-1:0]   w_slot0_tag;
        logic [IDX_W-1:0]   w_load_idx;
        logic               w_accept;
        logic [INF_W-1:0]   r_inflight;
        logic               r_done_valid;
        logic [TAG_W-1:0]   r_done_tag;

        // Pre-shift slot L is where the op would land after this edge's
        // shift. Slot MAX_LAT does not exist and is always free, which the
        // zero padding provides; the padding also keeps the 4-bit index legal.
        assign w_occ_ext  = {{(16 - MAX_LAT){1'b0}}, w_occ};
        assign w_ready    = ~w_occ_ext[w_eff_lat];
        assign w_accept   = issue_valid && w_ready && !flush;
        assign w_load_idx = IDX_W'(w_eff_lat - 4'd1);

        mc_slot_shift #(
            .DEPTH (MAX_LAT),
            .TAG_W (TAG_W),
            .IDX_W (IDX_W)
        ) u_slots (
            .clk         (clk),
            .rst         (rst),
            .clear       (flush),
            .shift       (1'b1),
            .load        (w_accept),
            .load_idx    (w_load_idx),
            .load_tag    (issue_tag),
            .slot0_valid (w_slot0_valid),
            .slot0_tag   (w_slot0_tag),
            .occ         (w_occ)
        );

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_inflight   <= '0;
                r_done_valid <= 1'b0;
                r_done_tag   <= '0;
            end else begin
                // Accept and completion on the same edge cancel out.
                r_inflight   <= r_inflight + INF_W'(w_accept) - INF_W'(w_slot0_valid);
                r_done_valid <= w_slot0_valid;
                r_done_tag   <= w_slot0_valid ? w_slot0_tag : '0;
            end
        end

        assign w_done_valid = r_done_valid;
        assign w_done_tag   = r_done_tag;
        assign w_inflight   = r_inflight;
    end

    assign issue_ready = w_ready;
    assign stall       = issue_valid & ~w_ready;
    assign done_valid  = w_done_valid;
    assign done_tag    = w_done_tag;
    assign inflight    = w_inflight;
    assign busy        = (w_inflight != '0);

endmodule
`default_nettype wire

// File: tb/tb_mc_latency_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_latency_ctrl
// Description : Self-checking bench for mc_latency_ctrl. A blocking instance
//               (index 0) and a pipelined instance (index 1) share the same
//               stimulus. The reference model is a completion calendar keyed
//               by absolute edge number: an accepted op with effective
//               latency L at edge e is entered at e+L; a flush or reset at
//               edge e erases every entry at e or later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_latency_ctrl;

    localparam int ML = 8;
    localparam int TW = 5;
    localparam int IW = $clog2(ML + 1);
    localparam int NE = 2048;

    logic                clk = 1'b0;
    logic                rst;
    logic                issue_valid;
    logic [3:0]          issue_lat;
    logic [TW-1:0]       issue_tag;
    logic                flush;
    logic [1:0]          rdy, stl, dv, bz;
    logic [1:0][TW-1:0]  dt;
    logic [1:0][IW-1:0]  inf;

    // Reference calendar: sv[m][k] = an op of instance m completes at edge k
    bit            sv [2][NE];
    logic [TW-1:0] st [2][NE];
    int            e;        // number of the coming edge
    int            n_chk;
    int            n_pass;

    always #5 clk = ~clk;

    mc_latency_ctrl #(.MAX_LAT(ML), .TAG_W(TW), .PIPELINED(0)) u_blk (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_lat(issue_lat),
        .issue_tag(issue_tag), .flush(flush), .issue_ready(rdy[0]), .stall(stl[0]),
        .done_valid(dv[0]), .done_tag(dt[0]), .busy(bz[0]), .inflight(inf[0])
    );

    mc_latency_ctrl #(.MAX_LAT(ML), .TAG_W(TW), .PIPELINED(1)) u_pipe (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_lat(issue_lat),
        .issue_tag(issue_tag), .flush(flush), .issue_ready(rdy[1]), .stall(stl[1]),
        .done_valid(dv[1]), .done_tag(dt[1]), .busy(bz[1]), .inflight(inf[1])
    );

    // ---------------- reference model ----------------
    function automatic int clampl(input logic [3:0] l);
        if (l == 4'd0) return 1;
        if (int'(l) > ML) return ML;
        return int'(l);
    endfunction

    function automatic int m_inflight(input int m);
        int n = 0;
        for (int k = e; k <= e + ML; k++) if (sv[m][k]) n++;
        return n;
    endfunction

    function automatic bit m_ready(input int m, input logic [3:0] l);
        if (m == 0) return (m_inflight(0) == 0) || (m_inflight(0) == 1 && sv[0][e]);
        return !sv[1][e + clampl(l)];
    endfunction

    function automatic bit m_done(input int m);
        return (e > 0) && sv[m][e-1];
    endfunction

    function automatic logic [TW-1:0] m_tag(input int m);
        return m_done(m) ? st[m][e-1] : '0;
    endfunction

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input int l, input int t, input bit f, input bit r);
        issue_valid = v;
        issue_lat   = 4'(l);
        issue_tag   = TW'(t);
        flush       = f;
        rst         = r;
        #1;
    endtask

    // Book the coming edge into the model, then advance to the next negedge.
    task automatic tick();
        for (int m = 0; m < 2; m++) begin
            if (rst || flush) begin
                for (int k = e; k <= e + ML; k++) sv[m][k] = 1'b0;
            end else if (issue_valid && m_ready(m, issue_lat)) begin
                sv[m][e + clampl(issue_lat)] = 1'b1;
                st[m][e + clampl(issue_lat)] = issue_tag;
            end
        end
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_in(1, 3, 9, 0, 1);      // op presented during reset must be dropped
        tick();
        tick();
        set_in(0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (dv[m] !== 1'b0)  $display("FAIL rst_done_valid m=%0d got=%b exp=0", m, dv[m]); else n_pass++;
            n_chk++; if (dt[m] !== '0)    $display("FAIL rst_done_tag m=%0d got=%0d exp=0", m, dt[m]); else n_pass++;
            n_chk++; if (inf[m] !== '0)   $display("FAIL rst_inflight m=%0d got=%0d exp=0", m, inf[m]); else n_pass++;
            n_chk++; if (bz[m] !== 1'b0)  $display("FAIL rst_busy m=%0d got=%b exp=0", m, bz[m]); else n_pass++;
            n_chk++; if (rdy[m] !== 1'b1) $display("FAIL rst_ready m=%0d got=%b exp=1", m, rdy[m]); else n_pass++;
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++; if (dv !== 2'b00) $display("FAIL rst_dropped_op c=%0d got=%b exp=00", c, dv); else n_pass++;
        end
    endtask

    task automatic test_blocking_lat7();
        set_in(1, 7, 3, 0, 0);
        n_chk++; if (rdy[0] !== 1'b1) $display("FAIL blk7_ready_e0 got=%b exp=1", rdy[0]); else n_pass++;
        tick();                                  // E0
        set_in(0, 0, 0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            tick();                              // now in the cycle after Ec
            if (c <= 6) begin
                n_chk++; if (rdy[0] !== (c == 6)) $display("FAIL blk7_ready c=%0d got=%b exp=%b", c, rdy[0], (c == 6)); else n_pass++;
                n_chk++; if (bz[0] !== 1'b1)      $display("FAIL blk7_busy c=%0d got=%b exp=1", c, bz[0]); else n_pass++;
                n_chk++; if (dv[0] !== 1'b0)      $display("FAIL blk7_early_done c=%0d got=%b exp=0", c, dv[0]); else n_pass++;
            end else if (c == 7) begin
                n_chk++; if (dv[0] !== 1'b1)   $display("FAIL blk7_done got=%b exp=1", dv[0]); else n_pass++;
                n_chk++; if (dt[0] !== 5'd3)   $display("FAIL blk7_tag got=%0d exp=3", dt[0]); else n_pass++;
            end else begin
                n_chk++; if (dv[0] !== 1'b0)   $display("FAIL blk7_pulse_len got=%b exp=0", dv[0]); else n_pass++;
                n_chk++; if (bz[0] !== 1'b0)   $display("FAIL blk7_idle_busy got=%b exp=0", bz[0]); else n_pass++;
            end
        end
    endtask

    task automatic test_pipe_conflict();
        set_in(1, 5, 1, 0, 0);
        n_chk++; if (rdy[1] !== 1'b1) $display("FAIL pcf_ready_e0 got=%b exp=1", rdy[1]); else n_pass++;
        tick();                                  // E0: lat5 tag1 -> E5
        set_in(1, 4, 2, 0, 0);
        n_chk++; if (rdy[1] !== 1'b0) $display("FAIL pcf_refuse_ready got=%b exp=0", rdy[1]); else n_pass++;
        n_chk++; if (stl[1] !== 1'b1) $display("FAIL pcf_stall got=%b exp=1", stl[1]); else n_pass++;
        tick();                                  // E1: refused (would also hit E5)
        set_in(1, 6, 2, 0, 0);
        n_chk++; if (rdy[1] !== 1'b1) $display("FAIL pcf_retry_ready got=%b exp=1", rdy[1]); else n_pass++;
        tick();                                  // E2: lat6 tag2 -> E8
        set_in(0, 0, 0, 0, 0);
        for (int c = 3; c <= 9; c++) begin
            tick();
            n_chk++; if (dv[1] !== (c == 5 || c == 8)) $display("FAIL pcf_done c=%0d got=%b", c, dv[1]); else n_pass++;
            n_chk++; if (dt[1] !== ((c == 5) ? 5'd1 : (c == 8) ? 5'd2 : 5'd0))
                $display("FAIL pcf_tag c=%0d got=%0d", c, dt[1]); else n_pass++;
        end
    endtask

    task automatic test_clamp();
        set_in(1, 0, 4, 0, 0);
        tick();                                  // E0, lat 0 -> 1
        set_in(0, 0, 0, 0, 0);
        n_chk++; if (dv !== 2'b00) $display("FAIL clamp0_early got=%b exp=00", dv); else n_pass++;
        tick();                                  // E1
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (dv[m] !== 1'b1) $display("FAIL clamp0_done m=%0d got=%b exp=1", m, dv[m]); else n_pass++;
            n_chk++; if (dt[m] !== 5'd4) $display("FAIL clamp0_tag m=%0d got=%0d exp=4", m, dt[m]); else n_pass++;
        end
        set_in(1, 12, 6, 0, 0);
        n_chk++; if (rdy !== 2'b11) $display("FAIL clamp12_ready got=%b exp=11", rdy); else n_pass++;
        tick();                                  // E0, lat 12 -> 8
        set_in(0, 0, 0, 0, 0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            n_chk++; if (dv !== ((c == 8) ? 2'b11 : 2'b00)) $display("FAIL clamp12_done c=%0d got=%b", c, dv); else n_pass++;
        end
        n_chk++; if (dt !== '0) $display("FAIL clamp12_tag_idle got=%h exp=0", dt); else n_pass++;
    endtask

    task automatic test_flush();
        set_in(1, 6, 7, 0, 0); tick();           // E0
        set_in(1, 3, 8, 0, 0); tick();           // E1 (pipelined only)
        set_in(0, 0, 0, 0, 0); tick();           // E2
        n_chk++; if (inf[1] !== IW'(2)) $display("FAIL flush_pre_inflight got=%0d exp=2", inf[1]); else n_pass++;
        n_chk++; if (inf[0] !== IW'(1)) $display("FAIL flush_pre_inflight_blk got=%0d exp=1", inf[0]); else n_pass++;
        set_in(1, 2, 9, 1, 0); tick();           // E3: flush, issue ignored
        set_in(0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (inf[m] !== '0)  $display("FAIL flush_inflight m=%0d got=%0d exp=0", m, inf[m]); else n_pass++;
            n_chk++; if (bz[m] !== 1'b0) $display("FAIL flush_busy m=%0d got=%b exp=0", m, bz[m]); else n_pass++;
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_chk++; if (dv !== 2'b00) $display("FAIL flush_no_done c=%0d got=%b exp=00", c, dv); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        set_in(1, 6, 10, 0, 0); tick();          // E0
        set_in(0, 0, 0, 0, 0);  tick();          // E1
        set_in(1, 2, 11, 0, 1); tick();          // E2: reset with an op presented
        set_in(0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_chk++; if (rdy[m] !== 1'b1) $display("FAIL rmid_ready m=%0d got=%b exp=1", m, rdy[m]); else n_pass++;
            n_chk++; if (inf[m] !== '0)   $display("FAIL rmid_inflight m=%0d got=%0d exp=0", m, inf[m]); else n_pass++;
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_chk++; if (dv !== 2'b00) $display("FAIL rmid_no_done c=%0d got=%b exp=00", c, dv); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit er;
        for (int i = 0; i < 1500; i++) begin
            set_in(($urandom_range(0, 9) < 7), $urandom_range(0, 15), $urandom_range(0, 31),
                   ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
            for (int m = 0; m < 2; m++) begin
                er = m_ready(m, issue_lat);
                n_chk++; if (rdy[m] !== er) $display("FAIL rnd_ready m=%0d e=%0d got=%b exp=%b", m, e, rdy[m], er); else n_pass++;
                n_chk++; if (stl[m] !== (issue_valid & ~er)) $display("FAIL rnd_stall m=%0d e=%0d got=%b exp=%b", m, e, stl[m], issue_valid & ~er); else n_pass++;
                n_chk++; if (dv[m] !== m_done(m)) $display("FAIL rnd_done m=%0d e=%0d got=%b exp=%b", m, e, dv[m], m_done(m)); else n_pass++;
                n_chk++; if (dt[m] !== m_tag(m)) $display("FAIL rnd_tag m=%0d e=%0d got=%0d exp=%0d", m, e, dt[m], m_tag(m)); else n_pass++;
                n_chk++; if (inf[m] !== IW'(m_inflight(m))) $display("FAIL rnd_inflight m=%0d e=%0d got=%0d exp=%0d", m, e, inf[m], m_inflight(m)); else n_pass++;
                n_chk++; if (bz[m] !== (m_inflight(m) != 0)) $display("FAIL rnd_busy m=%0d e=%0d got=%b", m, e, bz[m]); else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        e      = 0;
        issue_valid = 1'b0;
        issue_lat   = 4'd0;
        issue_tag   = '0;
        flush       = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        test_reset();
        test_blocking_lat7();
        idle(2);
        test_pipe_conflict();
        idle(2);
        test_clamp();
        idle(2);
        test_flush();
        idle(2);
        test_reset_mid();
        idle(2);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
